// File: rtl/quad_step_encoder.sv
// Quadrature rotary encoder front end for the up/down step counters.
// Synchronises and debounces both encoder channels and follows the Gray-code
// walk of the encoder. It emits one registered EN/cnt/inc request per full
// detent, or an err pulse when both channels change together.
module quad_step_encoder #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int FAST_WINDOW     = 1000
) (
    input  logic clk,
    input  logic rst,
    input  logic qa,
    input  logic qb,
    output logic EN,
    output logic cnt,
    output logic inc,
    output logic err
);

    localparam logic [7:0]  DB_LIMIT = 8'(DEBOUNCE_CYCLES);
    localparam logic [15:0] FW_LIMIT = 16'(FAST_WINDOW);

    logic [SYNC_STAGES-1:0] syncA_q, syncB_q;
    logic                   syncA, syncB;

    logic [7:0]        dbA_q, dbA_d, dbB_q, dbB_d;
    logic              fa_q, fa_d, fb_q, fb_d;
    logic [1:0]        prev_q, prev_d;
    logic [1:0]        filt;
    logic signed [3:0] acc_q, acc_d, accStep;
    logic [15:0]       timer_q, timer_d;
    logic              lastDir_q, lastDir_d;
    logic              en_q, en_d, cnt_q, cnt_d, inc_q, inc_d, err_q, err_d;

    logic stepUp, stepDown, illegal, evUp, evDown, evAny;

    assign syncA = syncA_q[SYNC_STAGES-1];
    assign syncB = syncB_q[SYNC_STAGES-1];
    assign filt  = {fa_q, fb_q};

    // Shift the raw pins through the metastability chains.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            syncA_q <= '0;
            syncB_q <= '0;
        end else begin
            syncA_q <= {syncA_q[SYNC_STAGES-2:0], qa};
            syncB_q <= {syncB_q[SYNC_STAGES-2:0], qb};
        end
    end

    // Per-channel debounce: accept a new level only after it has outlasted the stability count.
    always_comb begin
        fa_d  = fa_q;
        dbA_d = '0;
        fb_d  = fb_q;
        dbB_d = '0;
        if (syncA != fa_q) begin
            if (dbA_q == DB_LIMIT) begin
                fa_d = syncA;
            end else begin
                dbA_d = dbA_q + 8'd1;
            end
        end
        if (syncB != fb_q) begin
            if (dbB_q == DB_LIMIT) begin
                fb_d = syncB;
            end else begin
                dbB_d = dbB_q + 8'd1;
            end
        end
    end

    // Classify the filtered step and decide whether a detent completed.
    always_comb begin
        prev_d   = filt;
        stepUp   = ((prev_q == 2'b00) && (filt == 2'b01)) ||
                   ((prev_q == 2'b01) && (filt == 2'b11)) ||
                   ((prev_q == 2'b11) && (filt == 2'b10)) ||
                   ((prev_q == 2'b10) && (filt == 2'b00));
        stepDown = ((prev_q == 2'b00) && (filt == 2'b10)) ||
                   ((prev_q == 2'b10) && (filt == 2'b11)) ||
                   ((prev_q == 2'b11) && (filt == 2'b01)) ||
                   ((prev_q == 2'b01) && (filt == 2'b00));
        illegal  = ((prev_q ^ filt) == 2'b11);
        accStep  = acc_q;
        acc_d    = acc_q;
        evUp     = 1'b0;
        evDown   = 1'b0;
        if (illegal) begin
            acc_d = '0;
        end else if (stepUp || stepDown) begin
            accStep = stepUp ? (acc_q + 4'sd1) : (acc_q - 4'sd1);
            acc_d   = accStep;
            if (filt == 2'b00) begin
                evUp   = (accStep == 4'sd4);
                evDown = (accStep == -4'sd4);
                acc_d  = '0;
            end
        end
        evAny = evUp | evDown;
    end

    // Build the registered request outputs plus the fast-turn timer and direction memory.
    always_comb begin
        en_d      = evAny;
        err_d     = illegal;
        cnt_d     = cnt_q;
        inc_d     = inc_q;
        lastDir_d = lastDir_q;
        timer_d   = (timer_q < FW_LIMIT) ? (timer_q + 16'd1) : timer_q;
        if (evAny) begin
            cnt_d     = evDown;
            inc_d     = (timer_q < FW_LIMIT) && (evDown == lastDir_q);
            lastDir_d = evDown;
            timer_d   = '0;
        end
    end

    // State register for the filter, decoder and output stage.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dbA_q     <= '0;
            dbB_q     <= '0;
            fa_q      <= 1'b0;
            fb_q      <= 1'b0;
            prev_q    <= 2'b00;
            acc_q     <= '0;
            timer_q   <= FW_LIMIT;
            lastDir_q <= 1'b0;
            en_q      <= 1'b0;
            cnt_q     <= 1'b0;
            inc_q     <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            dbA_q     <= dbA_d;
            dbB_q     <= dbB_d;
            fa_q      <= fa_d;
            fb_q      <= fb_d;
            prev_q    <= prev_d;
            acc_q     <= acc_d;
            timer_q   <= timer_d;
            lastDir_q <= lastDir_d;
            en_q      <= en_d;
            cnt_q     <= cnt_d;
            inc_q     <= inc_d;
            err_q     <= err_d;
        end
    end

    assign EN  = en_q;
    assign cnt = cnt_q;
    assign inc = inc_q;
    assign err = err_q;

endmodule
